wmem_hidden_reader: RTL and testbench

Read-side sequencer for the hidden-layer weight memory. Accepts a (layer, neuron) row command, issues the N_IN consecutive read addresses of that row to the memory's 1-cycle-latency read port, and streams the returned weights to the MAC datapath over a valid/ready interface. A 2-entry output buffer with credit-based issue provides full throughput and lossless backpressure.

---
 rtl/wmem_hidden_reader.sv | 174 +++++++++++++++++
 tb/tb_wmem_hidden_reader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wmem_hidden_reader.sv
// Read-side sequencer for the hidden-layer weight memory: one row command in, N_IN weights out.
// Optional build macro WMEM_READER_RANGE_CHECK_EN rejects out-of-range (layer, neuron) commands.
module wmem_hidden_reader #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned N_IN        = 128,
    parameter int unsigned N_HIDDEN    = 64,
    parameter int unsigned N_LAYERS    = 3,
    localparam int unsigned WMEM_SIZE   = N_LAYERS * N_HIDDEN * N_IN,
    localparam int unsigned WMEM_ADDR_W = $clog2((WMEM_SIZE > 2) ? WMEM_SIZE : 2),
    localparam int unsigned LSTRIDE     = N_HIDDEN * N_IN,
    localparam int unsigned LW          = $clog2((N_LAYERS > 2) ? N_LAYERS : 2),
    localparam int unsigned HW          = $clog2((N_HIDDEN > 2) ? N_HIDDEN : 2),
    localparam int unsigned IW          = $clog2((N_IN > 2) ? N_IN : 2)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [LW-1:0]                 cmd_layer,
    input  logic [HW-1:0]                 cmd_neuron,
    output logic                          cmd_err,
    output logic [WMEM_ADDR_W-1:0]        raddr,
    input  logic signed [DATA_W-1:0]      mem_rdata,
    output logic                          w_valid,
    input  logic                          w_ready,
    output logic signed [DATA_W-1:0]      w_data,
    output logic [IW-1:0]                 w_idx,
    output logic                          w_last,
    output logic                          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

    state_t                   state;
    state_t                   state_d;
    logic [WMEM_ADDR_W-1:0]   base;
    logic [IW-1:0]            idx;
    logic                     inflight;
    logic [IW-1:0]            inflight_idx;

    logic signed [DATA_W-1:0] fifo_data [2];
    logic [IW-1:0]            fifo_idx  [2];
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               fifo_count;

    logic                     pop_c;
    logic [2:0]               occ_c;
    logic                     fire_c;
    logic                     accept_c;
    logic                     done_d;
    logic [WMEM_ADDR_W-1:0]   base_c;

    // Row base address, truncated to the memory address width.
    assign base_c = WMEM_ADDR_W'(32'(cmd_layer) * 32'(LSTRIDE) + 32'(cmd_neuron) * 32'(N_IN));

    assign cmd_ready = (state == IDLE) && !rst;
    assign raddr     = base + WMEM_ADDR_W'(idx);
    assign w_valid   = (fifo_count != 2'd0);
    assign w_data    = fifo_data[rd_ptr];
    assign w_idx     = fifo_idx[rd_ptr];
    assign w_last    = (fifo_idx[rd_ptr] == LAST_IDX);
    assign pop_c     = w_valid && w_ready;
    assign occ_c     = 3'(fifo_count) + 3'(inflight);

`ifdef WMEM_READER_RANGE_CHECK_EN
    logic reject_c;
    logic range_bad_c;
    assign range_bad_c = (32'(cmd_layer) >= N_LAYERS) || (32'(cmd_neuron) >= N_HIDDEN);
`else
    assign cmd_err = 1'b0;
`endif

    // Next-state, issue credit and completion decode.
    always_comb begin
        state_d  = state;
        fire_c   = 1'b0;
        accept_c = 1'b0;
        done_d   = 1'b0;
`ifdef WMEM_READER_RANGE_CHECK_EN
        reject_c = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
`ifdef WMEM_READER_RANGE_CHECK_EN
                    if (range_bad_c) begin
                        reject_c = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                        state_d  = ISSUE;
                    end
`else
                    accept_c = 1'b1;
                    state_d  = ISSUE;
`endif
                end
            end
            ISSUE: begin
                // A slot is free once this cycle's pop is accounted for.
                if ((occ_c - 3'(pop_c)) < 3'd2) begin
                    fire_c = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Finish on the edge that consumes the final buffered beat.
                if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop_c))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, address sequencing and the two-entry output buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base         <= '0;
            idx          <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_count   <= 2'd0;
            done         <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
            end
`ifdef WMEM_READER_RANGE_CHECK_EN
            cmd_err      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            done     <= done_d;
            inflight <= fire_c;
`ifdef WMEM_READER_RANGE_CHECK_EN
            cmd_err  <= reject_c;
`endif
            if (accept_c) begin
                base <= base_c;
                idx  <= '0;
            end
            // The last index is held so raddr never leaves the row.
            if (fire_c) begin
                inflight_idx <= idx;
                if (idx != LAST_IDX) begin
                    idx <= idx + IW'(1);
                end
            end
            if (inflight) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_idx[wr_ptr]  <= inflight_idx;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop_c) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(inflight) - 2'(pop_c);
        end
    end

endmodule

// File: tb/tb_wmem_hidden_reader.sv
// Directed bench for wmem_hidden_reader on a small 2x3x4 weight memory holding mem[a] = a + 100.
module tb_wmem_hidden_reader;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned N_IN     = 4;
    localparam int unsigned N_HIDDEN = 3;
    localparam int unsigned N_LAYERS = 2;
    localparam int unsigned AW       = 5;
    localparam int unsigned LW       = 1;
    localparam int unsigned HW       = 2;
    localparam int unsigned IW       = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic [LW-1:0]            cmd_layer = '0;
    logic [HW-1:0]            cmd_neuron = '0;
    logic                     cmd_err;
    logic [AW-1:0]            raddr;
    logic signed [DATA_W-1:0] mem_rdata = '0;
    logic                     w_valid;
    logic                     w_ready = 1'b0;
    logic signed [DATA_W-1:0] w_data;
    logic [IW-1:0]            w_idx;
    logic                     w_last;
    logic                     done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DATA_W-1:0] bq_data[$];
    int                bq_idx[$];
    bit                bq_last[$];
    int                bq_cyc[$];
    int                vrise[$];
    int                done_cnt = 0;
    int                done_cyc = -1;
    logic              done_ready = 1'b0;
    int                err_cnt = 0;
    int                err_cyc = -1;
    logic              prev_valid = 1'b0;

    wmem_hidden_reader #(
        .DATA_W  (DATA_W),
        .N_IN    (N_IN),
        .N_HIDDEN(N_HIDDEN),
        .N_LAYERS(N_LAYERS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_layer (cmd_layer),
        .cmd_neuron(cmd_neuron),
        .cmd_err   (cmd_err),
        .raddr     (raddr),
        .mem_rdata (mem_rdata),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory with one cycle of latency.
    always @(posedge clk) mem_rdata <= DATA_W'(32'(raddr) + 100);

    // Passive monitor; a beat seen here handshakes on the following rising edge.
    always @(negedge clk) begin
        if (w_valid === 1'b1 && w_ready === 1'b1) begin
            bq_data.push_back(w_data);
            bq_idx.push_back(int'(w_idx));
            bq_last.push_back(w_last);
            bq_cyc.push_back(cyc);
        end
        if (w_valid === 1'b1 && prev_valid !== 1'b1) vrise.push_back(cyc);
        prev_valid = w_valid;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc   = cyc;
            done_ready = cmd_ready;
        end
        if (cmd_err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic send_cmd(input int l, input int n, output int acc);
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_layer  = LW'(l);
        cmd_neuron = HW'(n);
        acc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL cmd_accept (%0d,%0d): not accepted within 40 cycles", l, n);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        for (int c = 0; c < 100 && done_cnt < target; c++) @(negedge clk);
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s_done_timeout: done count %0d, want %0d", name, done_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || w_valid !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b done=%b err=%b, want all 0", cmd_ready, w_valid, done, cmd_err);
        end
        checks++;
        if (raddr !== '0 || w_data !== '0 || w_idx !== '0 || w_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: raddr=%0d data=%0d idx=%0d last=%b, want 0", raddr, w_data, w_idx, w_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, want 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        int acc, b0, v0, d0;
        w_ready = 1'b1;
        b0 = bq_data.size(); v0 = vrise.size(); d0 = done_cnt;
        send_cmd(1, 2, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (raddr !== AW'(20 + ((i < 3) ? i : 3))) begin
                errors++;
                $display("FAIL basic_raddr%0d: got %0d, want %0d", i, raddr, 20 + ((i < 3) ? i : 3));
            end
        end
        wait_done(d0 + 1, "basic");
        checks++;
        if (bq_data.size() != b0 + 4) begin
            errors++;
            $display("FAIL basic_count: got %0d beats, want 4", bq_data.size() - b0);
        end
        for (int i = 0; i < 4 && b0 + i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[b0+i] !== 16'(120 + i) || bq_idx[b0+i] != i || bq_last[b0+i] !== (i == 3)) begin
                errors++;
                $display("FAIL basic_beat%0d: data=%0d idx=%0d last=%b, want data=%0d idx=%0d last=%b",
                         i, bq_data[b0+i], bq_idx[b0+i], bq_last[b0+i], 120 + i, i, (i == 3));
            end
        end
        checks++;
        if (vrise.size() <= v0 || vrise[v0] != acc + 2) begin
            errors++;
            $display("FAIL basic_latency: first valid cycle %0d, want %0d", (vrise.size() > v0) ? vrise[v0] : -1, acc + 2);
        end
        checks++;
        if (done_cyc != acc + 6 || done_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: cycle %0d ready %b, want cycle %0d ready 1", done_cyc, done_ready, acc + 6);
        end
    endtask

    task automatic test_toggle();
        int acc, b0, d0, rbad;
        w_ready = 1'b1; rbad = 0;
        b0 = bq_data.size(); d0 = done_cnt;
        send_cmd(1, 2, acc);
        for (int c = 0; c < 60 && done_cnt == d0; c++) begin
            @(posedge clk); #1;
            w_ready = ~w_ready;
            @(negedge clk);
            if (raddr < AW'(20) || raddr > AW'(23)) rbad++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL toggle_done_timeout: no done within 60 cycles");
        end
        checks++;
        if (rbad != 0) begin
            errors++;
            $display("FAIL toggle_raddr_range: %0d cycles outside 20..23, want 0", rbad);
        end
        checks++;
        if (bq_data.size() != b0 + 4) begin
            errors++;
            $display("FAIL toggle_count: got %0d beats, want 4", bq_data.size() - b0);
        end
        for (int i = 0; i < 4 && b0 + i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[b0+i] !== 16'(120 + i) || bq_idx[b0+i] != i) begin
                errors++;
                $display("FAIL toggle_beat%0d: data=%0d idx=%0d, want data=%0d idx=%0d", i, bq_data[b0+i], bq_idx[b0+i], 120 + i, i);
            end
        end
        w_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, b0, d0;
        w_ready = 1'b1;
        b0 = bq_data.size(); d0 = done_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_layer = 1'b0; cmd_neuron = 2'd0;
        acc1 = -1; acc2 = -1;
        for (int c = 0; c < 20 && acc1 < 0; c++) begin
            @(negedge clk);
            if (cmd_ready) acc1 = cyc + 1;
        end
        @(posedge clk); #1;
        cmd_layer = 1'b1;
        for (int c = 0; c < 20 && acc2 < 0; c++) begin
            @(negedge clk);
            if (cmd_ready) acc2 = cyc + 1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (acc1 < 0 || acc2 != acc1 + 7) begin
            errors++;
            $display("FAIL b2b_accept: second accept %0d, want %0d", acc2, acc1 + 7);
        end
        wait_done(d0 + 2, "b2b");
        checks++;
        if (bq_data.size() != b0 + 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats, want 8", bq_data.size() - b0);
        end
        for (int i = 0; i < 8 && b0 + i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[b0+i] !== 16'(((i < 4) ? 100 : 108) + i) || bq_idx[b0+i] != i % 4) begin
                errors++;
                $display("FAIL b2b_beat%0d: data=%0d idx=%0d, want data=%0d idx=%0d",
                         i, bq_data[b0+i], bq_idx[b0+i], ((i < 4) ? 100 : 108) + i, i % 4);
            end
        end
    endtask

    task automatic test_reset_mid_row();
        int acc, b0, b1, d0;
        w_ready = 1'b1;
        b0 = bq_data.size();
        send_cmd(0, 1, acc);
        for (int c = 0; c < 20 && bq_data.size() < b0 + 2; c++) @(negedge clk);
        checks++;
        if (bq_data.size() < b0 + 2) begin
            errors++;
            $display("FAIL midrst_beats: got %0d beats before reset, want 2", bq_data.size() - b0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (w_valid !== 1'b0 || cmd_ready !== 1'b0 || raddr !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: valid=%b ready=%b raddr=%0d done=%b, want 0 0 0 0", w_valid, cmd_ready, raddr, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        b1 = bq_data.size(); d0 = done_cnt;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || w_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: ready=%b valid=%b, want 1 0", cmd_ready, w_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bq_data.size() != b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL midrst_quiet: %0d stray beats %0d stray done, want 0 0", bq_data.size() - b1, done_cnt - d0);
        end
        send_cmd(0, 0, acc);
        wait_done(d0 + 1, "midrst");
        checks++;
        if (bq_data.size() != b1 + 4) begin
            errors++;
            $display("FAIL midrst_count: got %0d beats, want 4", bq_data.size() - b1);
        end
        for (int i = 0; i < 4 && b1 + i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[b1+i] !== 16'(100 + i) || bq_idx[b1+i] != i) begin
                errors++;
                $display("FAIL midrst_beat%0d: data=%0d idx=%0d, want data=%0d idx=%0d", i, bq_data[b1+i], bq_idx[b1+i], 100 + i, i);
            end
        end
    endtask

    task automatic test_stall();
        int acc, b0, d0, bad, rmax;
        w_ready = 1'b0; bad = 0; rmax = 0;
        b0 = bq_data.size(); d0 = done_cnt;
        send_cmd(0, 0, acc);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (int'(raddr) > rmax) rmax = int'(raddr);
            if (c >= 2 && (w_valid !== 1'b1 || w_data !== 16'sd100 || w_idx !== 2'd0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d cycles without stable beat 100/idx0, want 0", bad);
        end
        checks++;
        if (rmax != 2 || raddr !== AW'(2)) begin
            errors++;
            $display("FAIL stall_raddr: max %0d now %0d, want 2 2", rmax, raddr);
        end
        @(posedge clk); #1;
        w_ready = 1'b1;
        wait_done(d0 + 1, "stall");
        checks++;
        if (bq_data.size() != b0 + 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats, want 4", bq_data.size() - b0);
        end
        for (int i = 0; i < 4 && b0 + i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[b0+i] !== 16'(100 + i) || bq_cyc[b0+i] != bq_cyc[b0] + i) begin
                errors++;
                $display("FAIL stall_beat%0d: data=%0d cycle=%0d, want data=%0d cycle=%0d", i, bq_data[b0+i], bq_cyc[b0+i], 100 + i, bq_cyc[b0] + i);
            end
        end
    endtask

    task automatic test_range();
        int acc, b0, d0, e0;
        w_ready = 1'b1;
        b0 = bq_data.size(); d0 = done_cnt; e0 = err_cnt;
        send_cmd(1, 3, acc);
`ifdef WMEM_READER_RANGE_CHECK_EN
        repeat (8) @(negedge clk);
        checks++;
        if (err_cnt != e0 + 1 || err_cyc != acc) begin
            errors++;
            $display("FAIL range_err: %0d pulses at cycle %0d, want 1 at %0d", err_cnt - e0, err_cyc, acc);
        end
        checks++;
        if (bq_data.size() != b0 || done_cnt != d0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL range_quiet: beats=%0d done=%0d ready=%b, want 0 0 1", bq_data.size() - b0, done_cnt - d0, cmd_ready);
        end
`else
        wait_done(d0 + 1, "range");
        checks++;
        if (err_cnt != e0) begin
            errors++;
            $display("FAIL range_err: %0d pulses, want 0", err_cnt - e0);
        end
        checks++;
        if (bq_data.size() != b0 + 4) begin
            errors++;
            $display("FAIL range_count: got %0d beats, want 4", bq_data.size() - b0);
        end
        for (int i = 0; i < 4 && b0 + i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[b0+i] !== 16'(124 + i)) begin
                errors++;
                $display("FAIL range_beat%0d: data=%0d, want %0d", i, bq_data[b0+i], 124 + i);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_back_to_back();
        test_reset_mid_row();
        test_stall();
        test_range();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
